// File: rtl/seq_scan_ctrl.sv
// Serial pattern-scan sequencer: accepts a word, shifts it MSB-first through a
// PAT_W-bit window and reports match pulses, a match count and the first match position.
module seq_scan_ctrl #(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              match_pulse,
    output logic              done,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  first_pos,
    output logic              first_found
);

    // Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
    // in_ready is high only in IDLE and in_data is ignored at all other times.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(1) | (PAT_W'(1) << (PAT_W - 1));

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [PAT_W-1:0]   window_q, window_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic               overlap_q, overlap_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic [CNT_W-1:0]   first_pos_q, first_pos_d;
    logic               first_found_q, first_found_d;
    logic               match_pulse_q, match_pulse_d;
    logic               done_q, done_d;

    logic               scan_bit;
    logic [PAT_W-1:0]   win_next;
    logic [FILL_W-1:0]  fill_next;
    logic               hit;

    assign scan_bit  = shreg_q[DATA_W-1];
    assign win_next  = {window_q[PAT_W-2:0], scan_bit};
    assign fill_next = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    assign hit       = (fill_next == FILL_W'(PAT_W)) && (win_next == pattern_q);

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        window_d      = window_q;
        pattern_d     = pattern_q;
        overlap_d     = overlap_q;
        fill_d        = fill_q;
        bit_idx_d     = bit_idx_q;
        match_count_d = match_count_q;
        first_pos_d   = first_pos_q;
        first_found_d = first_found_q;
        match_pulse_d = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    overlap_d = cfg_overlap;
                end
                if (in_valid) begin
                    shreg_d       = in_data;
                    bit_idx_d     = '0;
                    window_d      = '0;
                    fill_d        = '0;
                    match_count_d = '0;
                    first_pos_d   = '0;
                    first_found_d = 1'b0;
                    state_d       = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d   = shreg_q << 1;
                window_d  = win_next;
                bit_idx_d = bit_idx_q + CNT_W'(1);
                // Non-overlapping mode forgets the matched bits so the next hit needs PAT_W new ones.
                fill_d    = (hit && !overlap_q) ? '0 : fill_next;
                if (hit) begin
                    match_pulse_d = 1'b1;
                    match_count_d = match_count_q + CNT_W'(1);
                    if (!first_found_q) begin
                        first_pos_d   = bit_idx_q;
                        first_found_d = 1'b1;
                    end
                end
                if (bit_idx_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            window_q      <= '0;
            pattern_q     <= PAT_RST;
            overlap_q     <= 1'b1;
            fill_q        <= '0;
            bit_idx_q     <= '0;
            match_count_q <= '0;
            first_pos_q   <= '0;
            first_found_q <= 1'b0;
            match_pulse_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            window_q      <= window_d;
            pattern_q     <= pattern_d;
            overlap_q     <= overlap_d;
            fill_q        <= fill_d;
            bit_idx_q     <= bit_idx_d;
            match_count_q <= match_count_d;
            first_pos_q   <= first_pos_d;
            first_found_q <= first_found_d;
            match_pulse_q <= match_pulse_d;
            done_q        <= done_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q == S_SHIFT);
    assign match_pulse = match_pulse_q;
    assign done        = done_q;
    assign match_count = match_count_q;
    assign first_pos   = first_pos_q;
    assign first_found = first_found_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed and randomized checks of seq_scan_ctrl against a sliding-slice reference model.
module tb_seq_scan_ctrl;

  localparam int DATA_W = 16;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 5;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              match_pulse;
  logic              done;
  logic [CNT_W-1:0]  match_count;
  logic [CNT_W-1:0]  first_pos;
  logic              first_found;

  int tests;
  int failed;

  logic [PAT_W-1:0] m_pat;
  bit               m_ovl;
  logic [CNT_W-1:0] exp_q[$];

  seq_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .busy        (busy),
    .match_pulse (match_pulse),
    .done        (done),
    .match_count (match_count),
    .first_pos   (first_pos),
    .first_found (first_found)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: every bit position k whose trailing PAT_W-bit slice equals the pattern;
  // without overlap a hit is kept only if it shares no bits with the previously kept one
  task automatic build_expect(input logic [DATA_W-1:0] w, input logic [PAT_W-1:0] p, input bit ovl);
    logic [DATA_W-1:0] sh;
    int last_end;
    exp_q.delete();
    last_end = -1;
    for (int k = PAT_W - 1; k < DATA_W; k++) begin
      sh = w >> (DATA_W - 1 - k);
      if (sh[PAT_W-1:0] == p && (ovl || (k - last_end) >= PAT_W)) begin
        exp_q.push_back(CNT_W'(k));
        last_end = k;
      end
    end
  endtask

  // driver tasks
  task automatic write_cfg(input logic [PAT_W-1:0] p, input bit ovl);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_overlap = ovl;
    tick();
    cfg_we = 1'b0;
    m_pat  = p;
    m_ovl  = ovl;
  endtask

  // called in the first cycle after acceptance; returns in the first IDLE cycle
  task automatic observe(input string tag, input logic [DATA_W-1:0] w, input bit poke);
    int  exp_cnt;
    int  exp_first;
    bit  exp_found;
    bit  exp_pulse;
    build_expect(w, m_pat, m_ovl);
    exp_cnt   = exp_q.size();
    exp_found = (exp_cnt > 0);
    exp_first = exp_found ? int'(exp_q[0]) : 0;
    for (int j = 1; j <= DATA_W + 1; j++) begin
      if (poke && j == 4) begin
        cfg_we      = 1'b1;
        cfg_pattern = ~m_pat;
        cfg_overlap = ~m_ovl;
      end
      if (poke && j == 5) cfg_we = 1'b0;
      exp_pulse = (exp_q.size() > 0) && (exp_q[0] == CNT_W'(j - 2));
      check({tag, "_match_pulse"}, match_pulse, exp_pulse);
      if (exp_pulse) void'(exp_q.pop_front());
      check({tag, "_done"}, done, (j == DATA_W + 1));
      check({tag, "_busy"}, busy, (j <= DATA_W));
      check({tag, "_in_ready_busy"}, in_ready, 1'b0);
      if (j == DATA_W + 1) begin
        check({tag, "_match_count"}, match_count, exp_cnt);
        check({tag, "_first_found"}, first_found, exp_found);
        check({tag, "_first_pos"}, first_pos, exp_first);
        check({tag, "_missed_pulses"}, exp_q.size(), 0);
      end
      tick();
    end
    check({tag, "_in_ready_after"}, in_ready, 1'b1);
    check({tag, "_count_hold"}, match_count, exp_cnt);
    check({tag, "_done_low"}, done, 1'b0);
  endtask

  task automatic scan(input string tag, input logic [DATA_W-1:0] w, input bit poke);
    in_valid = 1'b1;
    in_data  = w;
    check({tag, "_accept_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    observe(tag, w, poke);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    tests       = 0;
    failed      = 0;
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    m_pat       = 4'b1001;
    m_ovl       = 1'b1;

    // 1: reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_match_pulse", match_pulse, 1'b0);
    check("rst_match_count", match_count, 0);
    check("rst_first_pos", first_pos, 0);
    check("rst_first_found", first_found, 1'b0);

    // 2: default pattern 1001, overlapping
    scan("t2_9000", 16'h9000, 1'b0);

    // 3: overlap vs non-overlap
    scan("t3_9240_ovl", 16'h9240, 1'b0);
    write_cfg(4'b1001, 1'b0);
    scan("t3_9240_novl", 16'h9240, 1'b0);

    // 4: pattern 1111, mid-scan cfg write ignored, no-match word
    write_cfg(4'b1111, 1'b1);
    scan("t4_ffff_ovl", 16'hFFFF, 1'b0);
    write_cfg(4'b1111, 1'b0);
    scan("t4_ffff_novl", 16'hFFFF, 1'b1);
    scan("t4_ffff_after_poke", 16'hFFFF, 1'b0);
    scan("t4_zero", 16'h0000, 1'b0);

    // 5: reset mid-scan
    in_valid = 1'b1;
    in_data  = 16'h9240;
    tick();
    in_valid = 1'b0;
    for (int j = 1; j < 8; j++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_in_ready", in_ready, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_match_count", match_count, 0);
    check("t5_first_found", first_found, 1'b0);
    check("t5_match_pulse", match_pulse, 1'b0);
    for (int j = 0; j < DATA_W; j++) begin
      check("t5_no_done", done, 1'b0);
      tick();
    end
    m_pat = 4'b1001;
    m_ovl = 1'b1;
    scan("t5_pattern_restored", 16'h9240, 1'b0);

    // 6: in_valid held high, back-to-back words
    in_valid = 1'b1;
    in_data  = 16'h9000;
    check("t6_accept_ready", in_ready, 1'b1);
    tick();
    in_data = 16'h0009;
    observe("t6_first", 16'h9000, 1'b0);
    tick();
    in_valid = 1'b0;
    observe("t6_second", 16'h0009, 1'b0);

    // randomized words and configurations
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0)
        write_cfg(PAT_W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0)
        w = {(DATA_W / PAT_W){m_pat}} ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1));
      else
        w = DATA_W'($urandom);
      scan("rand", w, 1'($urandom_range(0, 3) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
